// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, runs the imem req/ready handshake and feeds the IF/ID register.
// Optional IFU_BUBBLE_CNT_EN adds a saturating bubble_cnt output counting idle IF/ID cycles.
module instr_fetch_unit #(
  parameter int unsigned    PC_W     = 12,
  parameter int unsigned    INST_W   = 19,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              if_ld,
  output logic              if_flush,
  output logic [INST_W-1:0] if_inst,
`ifdef IFU_BUBBLE_CNT_EN
  output logic [PC_W-1:0]   if_pcplus,
  output logic [15:0]       bubble_cnt
`else
  output logic [PC_W-1:0]   if_pcplus
`endif
);

  typedef enum logic [1:0] {StFetch, StHold, StDrain} state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [PC_W-1:0]     r_pc;
  logic [PC_W-1:0]     w_pc_nxt;
  logic [PC_W-1:0]     w_pc_inc;
  logic [INST_W-1:0]   r_hold_inst;
  logic [INST_W-1:0]   w_hold_nxt;
  logic [PC_W-1:0]     r_drain_addr;
  logic [PC_W-1:0]     w_drain_addr_nxt;

  assign w_pc_inc = r_pc + {{(PC_W-1){1'b0}}, 1'b1};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StFetch;
      r_pc         <= RESET_PC;
      r_hold_inst  <= '0;
      r_drain_addr <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_hold_inst  <= w_hold_nxt;
      r_drain_addr <= w_drain_addr_nxt;
    end
  end

  // Next-state logic; redirect wins over stall and a same-cycle ready
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_hold_nxt       = r_hold_inst;
    w_drain_addr_nxt = r_drain_addr;
    unique case (r_state)
      StFetch: begin
        if (redirect) begin
          w_pc_nxt = redirect_pc;
          if (!imem_ready) begin
            // Request still outstanding: remember its address to finish the handshake
            w_state_nxt      = StDrain;
            w_drain_addr_nxt = r_pc;
          end
        end else if (imem_ready) begin
          if (stall) begin
            w_hold_nxt  = imem_rdata;
            w_state_nxt = StHold;
          end else begin
            w_pc_nxt = w_pc_inc;
          end
        end
      end
      StHold: begin
        if (redirect) begin
          w_pc_nxt    = redirect_pc;
          w_state_nxt = StFetch;
        end else if (!stall) begin
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = StFetch;
        end
      end
      StDrain: begin
        if (redirect) begin
          w_pc_nxt = redirect_pc;
        end else if (imem_ready) begin
          w_state_nxt = StFetch;
        end
      end
      default: w_state_nxt = StFetch;
    endcase
  end

  // Outputs; everything is forced low while reset is asserted
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = '0;
    if_ld     = 1'b0;
    if_flush  = 1'b0;
    if_inst   = '0;
    if_pcplus = '0;
    if (rst_n) begin
      imem_addr = (r_state == StDrain) ? r_drain_addr : r_pc;
      unique case (r_state)
        StFetch: begin
          imem_req = 1'b1;
          if (imem_ready && !stall) begin
            if_ld     = 1'b1;
            if_inst   = imem_rdata;
            if_pcplus = w_pc_inc;
          end
        end
        StHold: begin
          if_inst   = r_hold_inst;
          if_pcplus = w_pc_inc;
          if_ld     = !stall;
        end
        StDrain: imem_req = 1'b1;
        default: ;
      endcase
      if (redirect) begin
        if_flush = 1'b1;
        if_ld    = 1'b0;
      end
    end
  end

`ifdef IFU_BUBBLE_CNT_EN
  logic [15:0] r_bubble_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_cnt <= '0;
    end else if (!if_ld && (r_bubble_cnt != 16'hFFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
